// File: rtl/decode_stage.sv
// decode_stage: RV32I (optionally RV32M) instruction decode with a
// valid/ready handshake on both sides.
//
// Parameters
//   M_EXT : 1 enables decoding of the MUL/DIV/REM family.
//   SKID  : 1 gives an output register plus one skid entry with a registered
//           in_ready; 0 gives a single output register.
//   PC_W  : width of the PC carried with each instruction.
//
// Ports
//   clk, rst_n          clock and asynchronous active-low reset
//   flush               drops every held bundle and the incoming instruction
//   in_valid/in_ready   upstream handshake; in_ir/in_pc are the instruction
//   out_valid/out_ready downstream handshake; the remaining outputs are the
//                       decoded bundle (register numbers, immediate, ALU code,
//                       operand sources and control flags)
//   illegal_cnt         saturating count of illegal bundles handed downstream
//
// ALU codes and operand source codes are defined as localparams below.
module decode_stage #(
  parameter int M_EXT = 0,
  parameter int SKID  = 1,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      srcreg1_num,
  output logic [4:0]      srcreg2_num,
  output logic [4:0]      dstreg_num,
  output logic [31:0]     imm,
  output logic [5:0]      alucode,
  output logic [1:0]      aluop1_type,
  output logic [1:0]      aluop2_type,
  output logic            reg_we,
  output logic            is_load,
  output logic            is_store,
  output logic            is_halt,
  output logic            is_illegal,
  output logic [7:0]      illegal_cnt
);

  // ALU operation codes
  localparam logic [5:0] ALU_LUI  = 6'd0;
  localparam logic [5:0] ALU_JAL  = 6'd1;
  localparam logic [5:0] ALU_JALR = 6'd2;
  localparam logic [5:0] ALU_BEQ  = 6'd3;
  localparam logic [5:0] ALU_BNE  = 6'd4;
  localparam logic [5:0] ALU_BLT  = 6'd5;
  localparam logic [5:0] ALU_BGE  = 6'd6;
  localparam logic [5:0] ALU_BLTU = 6'd7;
  localparam logic [5:0] ALU_BGEU = 6'd8;
  localparam logic [5:0] ALU_LB   = 6'd9;
  localparam logic [5:0] ALU_LH   = 6'd10;
  localparam logic [5:0] ALU_LW   = 6'd11;
  localparam logic [5:0] ALU_LBU  = 6'd12;
  localparam logic [5:0] ALU_LHU  = 6'd13;
  localparam logic [5:0] ALU_SB   = 6'd14;
  localparam logic [5:0] ALU_SH   = 6'd15;
  localparam logic [5:0] ALU_SW   = 6'd16;
  localparam logic [5:0] ALU_ADD  = 6'd17;
  localparam logic [5:0] ALU_SUB  = 6'd18;
  localparam logic [5:0] ALU_XOR  = 6'd19;
  localparam logic [5:0] ALU_OR   = 6'd20;
  localparam logic [5:0] ALU_AND  = 6'd21;
  localparam logic [5:0] ALU_SLL  = 6'd22;
  localparam logic [5:0] ALU_SRL  = 6'd23;
  localparam logic [5:0] ALU_SRA  = 6'd24;
  localparam logic [5:0] ALU_SLT  = 6'd25;
  localparam logic [5:0] ALU_SLTU = 6'd26;
  // MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU occupy 27..34 in funct3 order
  localparam logic [5:0] ALU_MUL  = 6'd27;
  localparam logic [5:0] ALU_NOP  = 6'd63;

  // Operand source codes
  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_REG  = 2'd1;
  localparam logic [1:0] OP_IMM  = 2'd2;
  localparam logic [1:0] OP_PC   = 2'd3;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     imm;
    logic [5:0]      alucode;
    logic [1:0]      op1;
    logic [1:0]      op2;
    logic            reg_we;
    logic            is_load;
    logic            is_store;
    logic            is_halt;
    logic            is_illegal;
  } bundle_t;

  // ---------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------
  bundle_t     dec;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        writes_rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opcode = in_ir[6:0];
  assign f3     = in_ir[14:12];
  assign f7     = in_ir[31:25];
  assign imm_i  = {{20{in_ir[31]}}, in_ir[31:20]};
  assign imm_s  = {{20{in_ir[31]}}, in_ir[31:25], in_ir[11:7]};
  assign imm_b  = {{19{in_ir[31]}}, in_ir[31], in_ir[7], in_ir[30:25], in_ir[11:8], 1'b0};
  assign imm_u  = {in_ir[31:12], 12'b0};
  assign imm_j  = {{11{in_ir[31]}}, in_ir[31], in_ir[19:12], in_ir[20], in_ir[30:21], 1'b0};
  assign imm_sh = {27'b0, in_ir[24:20]};

  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.alucode = ALU_NOP;
    writes_rd  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec.rd = in_ir[11:7]; dec.imm = imm_u;
        dec.alucode = ALU_LUI; dec.op2 = OP_IMM; writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        dec.rd = in_ir[11:7]; dec.imm = imm_u;
        dec.alucode = ALU_ADD; dec.op1 = OP_PC; dec.op2 = OP_IMM; writes_rd = 1'b1;
      end
      OPC_JAL: begin
        dec.rd = in_ir[11:7]; dec.imm = imm_j;
        dec.alucode = ALU_JAL; dec.op1 = OP_PC; dec.op2 = OP_IMM; writes_rd = 1'b1;
      end
      OPC_JALR: begin
        dec.rs1 = in_ir[19:15]; dec.rd = in_ir[11:7]; dec.imm = imm_i;
        dec.alucode = ALU_JALR; dec.op1 = OP_REG; dec.op2 = OP_IMM; writes_rd = 1'b1;
      end
      OPC_BRANCH: begin
        dec.rs1 = in_ir[19:15]; dec.rs2 = in_ir[24:20]; dec.imm = imm_b;
        dec.op1 = OP_REG; dec.op2 = OP_REG;
        case (f3)
          3'b000:  dec.alucode = ALU_BEQ;
          3'b001:  dec.alucode = ALU_BNE;
          3'b100:  dec.alucode = ALU_BLT;
          3'b101:  dec.alucode = ALU_BGE;
          3'b110:  dec.alucode = ALU_BLTU;
          3'b111:  dec.alucode = ALU_BGEU;
          default: dec.is_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.rs1 = in_ir[19:15]; dec.rd = in_ir[11:7]; dec.imm = imm_i;
        dec.op1 = OP_REG; dec.op2 = OP_IMM; dec.is_load = 1'b1; writes_rd = 1'b1;
        case (f3)
          3'b000:  dec.alucode = ALU_LB;
          3'b001:  dec.alucode = ALU_LH;
          3'b010:  dec.alucode = ALU_LW;
          3'b100:  dec.alucode = ALU_LBU;
          3'b101:  dec.alucode = ALU_LHU;
          default: dec.is_illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.rs1 = in_ir[19:15]; dec.rs2 = in_ir[24:20]; dec.imm = imm_s;
        dec.op1 = OP_REG; dec.op2 = OP_REG; dec.is_store = 1'b1;
        case (f3)
          3'b000:  dec.alucode = ALU_SB;
          3'b001:  dec.alucode = ALU_SH;
          3'b010:  dec.alucode = ALU_SW;
          default: dec.is_illegal = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec.rs1 = in_ir[19:15]; dec.rd = in_ir[11:7]; dec.imm = imm_i;
        dec.op1 = OP_REG; dec.op2 = OP_IMM; writes_rd = 1'b1;
        case (f3)
          3'b000: dec.alucode = ALU_ADD;
          3'b010: dec.alucode = ALU_SLT;
          3'b011: dec.alucode = ALU_SLTU;
          3'b100: dec.alucode = ALU_XOR;
          3'b110: dec.alucode = ALU_OR;
          3'b111: dec.alucode = ALU_AND;
          3'b001: begin
            dec.imm = imm_sh;
            dec.alucode = ALU_SLL;
            if (f7 != 7'b0000000) dec.is_illegal = 1'b1;
          end
          default: begin  // 3'b101: SRLI / SRAI selected by ir[30]
            dec.imm = imm_sh;
            if (f7 == 7'b0000000)      dec.alucode = ALU_SRL;
            else if (f7 == 7'b0100000) dec.alucode = ALU_SRA;
            else                       dec.is_illegal = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        dec.rs1 = in_ir[19:15]; dec.rs2 = in_ir[24:20]; dec.rd = in_ir[11:7];
        dec.op1 = OP_REG; dec.op2 = OP_REG; writes_rd = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec.alucode = ALU_ADD;
            3'b001:  dec.alucode = ALU_SLL;
            3'b010:  dec.alucode = ALU_SLT;
            3'b011:  dec.alucode = ALU_SLTU;
            3'b100:  dec.alucode = ALU_XOR;
            3'b101:  dec.alucode = ALU_SRL;
            3'b110:  dec.alucode = ALU_OR;
            default: dec.alucode = ALU_AND;
          endcase
        end else if (f7 == 7'b0100000) begin
          if (f3 == 3'b000)      dec.alucode = ALU_SUB;
          else if (f3 == 3'b101) dec.alucode = ALU_SRA;
          else                   dec.is_illegal = 1'b1;
        end else if ((f7 == 7'b0000001) && (M_EXT != 0)) begin
          dec.alucode = ALU_MUL + {3'b000, f3};
        end else begin
          dec.is_illegal = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        // Only ECALL and EBREAK are supported; both stop the core
        if ((in_ir == 32'h0000_0073) || (in_ir == 32'h0010_0073)) dec.is_halt = 1'b1;
        else                                                      dec.is_illegal = 1'b1;
      end
      default: dec.is_illegal = 1'b1;
    endcase

    dec.reg_we = writes_rd && (in_ir[11:7] != 5'd0);

    // An illegal word must not cause any architectural side effect downstream
    if (dec.is_illegal) begin
      dec.alucode  = ALU_NOP;
      dec.op1      = OP_NONE;
      dec.op2      = OP_NONE;
      dec.reg_we   = 1'b0;
      dec.is_load  = 1'b0;
      dec.is_store = 1'b0;
      dec.is_halt  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Output register, optional skid entry, handshake
  // ---------------------------------------------------------------------
  bundle_t    out_bundle_reg, out_bundle_next;
  bundle_t    skid_bundle_reg, skid_bundle_next;
  logic       out_valid_reg, out_valid_next;
  logic       skid_full_reg, skid_full_next;
  logic       ready_reg;
  logic [7:0] illegal_cnt_reg, illegal_cnt_next;
  logic       out_fire, accept;

  // ready_reg is 0 in reset and tracks !skid_full afterwards; with SKID=0 the
  // skid entry never fills, so it simply becomes 1 after reset.
  assign in_ready = (SKID != 0) ? ready_reg
                                : (ready_reg && (!out_valid_reg || out_ready));
  assign out_fire = out_valid_reg && out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    out_bundle_next  = out_bundle_reg;
    skid_bundle_next = skid_bundle_reg;
    out_valid_next   = out_valid_reg;
    skid_full_next   = skid_full_reg;
    illegal_cnt_next = illegal_cnt_reg;

    if (flush) begin
      out_valid_next = 1'b0;
      skid_full_next = 1'b0;
    end else if (!out_valid_reg || out_fire) begin
      // Output slot frees up: the older skid bundle always goes first
      if (skid_full_reg) begin
        out_bundle_next = skid_bundle_reg;
        out_valid_next  = 1'b1;
        skid_full_next  = 1'b0;
      end else if (accept) begin
        out_bundle_next = dec;
        out_valid_next  = 1'b1;
      end else begin
        out_valid_next  = 1'b0;
      end
    end else if (accept && (SKID != 0)) begin
      skid_bundle_next = dec;
      skid_full_next   = 1'b1;
    end

    // The downstream consumer saw this bundle, so it counts even under flush
    if (out_fire && out_bundle_reg.is_illegal && (illegal_cnt_reg != 8'hFF))
      illegal_cnt_next = illegal_cnt_reg + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_bundle_reg  <= '0;
      skid_bundle_reg <= '0;
      out_valid_reg   <= 1'b0;
      skid_full_reg   <= 1'b0;
      ready_reg       <= 1'b0;
      illegal_cnt_reg <= 8'd0;
    end else begin
      out_bundle_reg  <= out_bundle_next;
      skid_bundle_reg <= skid_bundle_next;
      out_valid_reg   <= out_valid_next;
      skid_full_reg   <= skid_full_next;
      ready_reg       <= !skid_full_next;
      illegal_cnt_reg <= illegal_cnt_next;
    end
  end

  assign out_valid   = out_valid_reg;
  assign out_pc      = out_bundle_reg.pc;
  assign srcreg1_num = out_bundle_reg.rs1;
  assign srcreg2_num = out_bundle_reg.rs2;
  assign dstreg_num  = out_bundle_reg.rd;
  assign imm         = out_bundle_reg.imm;
  assign alucode     = out_bundle_reg.alucode;
  assign aluop1_type = out_bundle_reg.op1;
  assign aluop2_type = out_bundle_reg.op2;
  assign reg_we      = out_bundle_reg.reg_we;
  assign is_load     = out_bundle_reg.is_load;
  assign is_store    = out_bundle_reg.is_store;
  assign is_halt     = out_bundle_reg.is_halt;
  assign is_illegal  = out_bundle_reg.is_illegal;
  assign illegal_cnt = illegal_cnt_reg;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed self-checking bench for decode_stage.
// dut   : M_EXT=0, SKID=1 (default configuration)
// dut_m : M_EXT=1, SKID=0
module tb_decode_stage;

  localparam logic [5:0] ALU_LUI  = 6'd0;
  localparam logic [5:0] ALU_JAL  = 6'd1;
  localparam logic [5:0] ALU_BNE  = 6'd4;
  localparam logic [5:0] ALU_LW   = 6'd11;
  localparam logic [5:0] ALU_SW   = 6'd16;
  localparam logic [5:0] ALU_ADD  = 6'd17;
  localparam logic [5:0] ALU_SUB  = 6'd18;
  localparam logic [5:0] ALU_AND  = 6'd21;
  localparam logic [5:0] ALU_SRA  = 6'd24;
  localparam logic [5:0] ALU_MUL  = 6'd27;
  localparam logic [5:0] ALU_DIVU = 6'd32;
  localparam logic [5:0] ALU_NOP  = 6'd63;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_ir = '0, in_pc = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, imm;
  logic [4:0]  src1, src2, dst;
  logic [5:0]  alucode;
  logic [1:0]  op1t, op2t;
  logic        reg_we, is_load, is_store, is_halt, is_illegal;
  logic [7:0]  illegal_cnt;

  // M-extension, no-skid instance
  logic        flush_m = 1'b0, in_valid_m = 1'b0, out_ready_m = 1'b0;
  logic [31:0] in_ir_m = '0, in_pc_m = '0;
  logic        in_ready_m, out_valid_m;
  logic [31:0] out_pc_m, imm_m;
  logic [4:0]  src1_m, src2_m, dst_m;
  logic [5:0]  alucode_m;
  logic [1:0]  op1t_m, op2t_m;
  logic        reg_we_m, is_load_m, is_store_m, is_halt_m, is_illegal_m;
  logic [7:0]  illegal_cnt_m;

  int check_count = 0;
  int pass_count  = 0;

  decode_stage #(.M_EXT(0), .SKID(1), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .srcreg1_num(src1), .srcreg2_num(src2), .dstreg_num(dst),
    .imm(imm), .alucode(alucode), .aluop1_type(op1t), .aluop2_type(op2t),
    .reg_we(reg_we), .is_load(is_load), .is_store(is_store),
    .is_halt(is_halt), .is_illegal(is_illegal), .illegal_cnt(illegal_cnt)
  );

  decode_stage #(.M_EXT(1), .SKID(0), .PC_W(32)) dut_m (
    .clk(clk), .rst_n(rst_n), .flush(flush_m),
    .in_valid(in_valid_m), .in_ready(in_ready_m), .in_ir(in_ir_m), .in_pc(in_pc_m),
    .out_valid(out_valid_m), .out_ready(out_ready_m), .out_pc(out_pc_m),
    .srcreg1_num(src1_m), .srcreg2_num(src2_m), .dstreg_num(dst_m),
    .imm(imm_m), .alucode(alucode_m), .aluop1_type(op1t_m), .aluop2_type(op2t_m),
    .reg_we(reg_we_m), .is_load(is_load_m), .is_store(is_store_m),
    .is_halt(is_halt_m), .is_illegal(is_illegal_m), .illegal_cnt(illegal_cnt_m)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    check_count++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else pass_count++;
    check_count++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b expected 0", in_ready); else pass_count++;
    check_count++; if (illegal_cnt !== 8'd0) $display("FAIL rst_illegal_cnt: got %0d expected 0", illegal_cnt); else pass_count++;
    check_count++; if ({imm, alucode, reg_we} !== 39'd0) $display("FAIL rst_bundle: got %h expected 0", {imm, alucode, reg_we}); else pass_count++;
    check_count++; if (in_ready_m !== 1'b0) $display("FAIL rst_in_ready_m: got %b expected 0", in_ready_m); else pass_count++;
    rst_n = 1'b1;
    tick();
    check_count++; if (in_ready !== 1'b1) $display("FAIL rst_first_ready: got %b expected 1", in_ready); else pass_count++;
    check_count++; if (in_ready_m !== 1'b1) $display("FAIL rst_first_ready_m: got %b expected 1", in_ready_m); else pass_count++;
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    in_valid = 1'b1; in_ir = 32'h0050_0093; in_pc = 32'h100;
    tick();
    in_valid = 1'b0;
    $display("addi: valid=%b rd=%0d rs1=%0d imm=%0d alu=%0d we=%b", out_valid, dst, src1, imm, alucode, reg_we);
    check_count++; if (out_valid !== 1'b1) $display("FAIL addi_valid: got %b expected 1", out_valid); else pass_count++;
    check_count++; if ({dst, src1, src2} !== {5'd1, 5'd0, 5'd0}) $display("FAIL addi_regs: got %h expected %h", {dst, src1, src2}, {5'd1, 5'd0, 5'd0}); else pass_count++;
    check_count++; if (imm !== 32'd5) $display("FAIL addi_imm: got %h expected 5", imm); else pass_count++;
    check_count++; if (alucode !== ALU_ADD) $display("FAIL addi_alu: got %0d expected %0d", alucode, ALU_ADD); else pass_count++;
    check_count++; if (reg_we !== 1'b1) $display("FAIL addi_we: got %b expected 1", reg_we); else pass_count++;
    check_count++; if ({op1t, op2t} !== 4'b0110) $display("FAIL addi_optype: got %b expected 0110", {op1t, op2t}); else pass_count++;
    check_count++; if (out_pc !== 32'h100) $display("FAIL addi_pc: got %h expected 100", out_pc); else pass_count++;
    tick();
    check_count++; if (out_valid !== 1'b0) $display("FAIL addi_drain: got %b expected 0", out_valid); else pass_count++;
  endtask

  task automatic test_jal();
    out_ready = 1'b1;
    in_valid = 1'b1; in_ir = 32'h0080_006F; in_pc = 32'h140;
    tick();
    $display("jal x0: rd=%0d imm=%0d alu=%0d we=%b", dst, imm, alucode, reg_we);
    check_count++; if ({dst, imm, alucode, reg_we} !== {5'd0, 32'd8, ALU_JAL, 1'b0}) $display("FAIL jal_x0: got %h expected %h", {dst, imm, alucode, reg_we}, {5'd0, 32'd8, ALU_JAL, 1'b0}); else pass_count++;
    in_ir = 32'h0080_00EF; in_pc = 32'h144;
    tick();
    in_valid = 1'b0;
    $display("jal x1: rd=%0d imm=%0d alu=%0d we=%b", dst, imm, alucode, reg_we);
    check_count++; if ({dst, imm, alucode, reg_we} !== {5'd1, 32'd8, ALU_JAL, 1'b1}) $display("FAIL jal_x1: got %h expected %h", {dst, imm, alucode, reg_we}, {5'd1, 32'd8, ALU_JAL, 1'b1}); else pass_count++;
    check_count++; if (out_pc !== 32'h144) $display("FAIL jal_x1_pc: got %h expected 144", out_pc); else pass_count++;
    tick();
  endtask

  task automatic test_decode_table();
    logic [31:0] irs  [13];
    logic [57:0] exps [13];
    logic [57:0] got;
    // {rd, rs1, rs2, imm, alucode, we, load, store, halt, illegal}
    irs[0]  = 32'h00C1_2283; exps[0]  = {5'd5,  5'd2, 5'd0, 32'd12,         ALU_LW,  5'b11000}; // lw x5,12(x2)
    irs[1]  = 32'hFE63_AE23; exps[1]  = {5'd0,  5'd7, 5'd6, 32'hFFFF_FFFC,  ALU_SW,  5'b00100}; // sw x6,-4(x7)
    irs[2]  = 32'h1234_5537; exps[2]  = {5'd10, 5'd0, 5'd0, 32'h1234_5000,  ALU_LUI, 5'b10000}; // lui x10
    irs[3]  = 32'h4072_5193; exps[3]  = {5'd3,  5'd4, 5'd0, 32'd7,          ALU_SRA, 5'b10000}; // srai x3,x4,7
    irs[4]  = 32'h4031_00B3; exps[4]  = {5'd1,  5'd2, 5'd3, 32'd0,          ALU_SUB, 5'b10000}; // sub x1,x2,x3
    irs[5]  = 32'hFE20_9CE3; exps[5]  = {5'd0,  5'd1, 5'd2, 32'hFFFF_FFF8,  ALU_BNE, 5'b00000}; // bne x1,x2,-8
    irs[6]  = 32'h0000_0073; exps[6]  = {5'd0,  5'd0, 5'd0, 32'd0,          ALU_NOP, 5'b00010}; // ecall
    irs[7]  = 32'h0010_0073; exps[7]  = {5'd0,  5'd0, 5'd0, 32'd0,          ALU_NOP, 5'b00010}; // ebreak
    irs[8]  = 32'hFFFF_FFFF; exps[8]  = {5'd0,  5'd0, 5'd0, 32'd0,          ALU_NOP, 5'b00001}; // unknown opcode
    irs[9]  = 32'h0220_81B3; exps[9]  = {5'd3,  5'd1, 5'd2, 32'd0,          ALU_NOP, 5'b00001}; // mul, M_EXT=0
    irs[10] = 32'h4010_9093; exps[10] = {5'd1,  5'd1, 5'd0, 32'd1,          ALU_NOP, 5'b00001}; // slli bad funct7
    irs[11] = 32'h3052_9073; exps[11] = {5'd0,  5'd0, 5'd0, 32'd0,          ALU_NOP, 5'b00001}; // csrrw
    irs[12] = 32'hFFF4_7393; exps[12] = {5'd7,  5'd8, 5'd0, 32'hFFFF_FFFF,  ALU_AND, 5'b10000}; // andi x7,x8,-1
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1; in_ir = irs[i]; in_pc = 32'h200 + 32'(4 * i);
      tick();
      got = {dst, src1, src2, imm, alucode, reg_we, is_load, is_store, is_halt, is_illegal};
      $display("vec %0d ir=%h -> %h", i, irs[i], got);
      check_count++; if (got !== exps[i]) $display("FAIL decode_vec%0d: got %h expected %h", i, got, exps[i]); else pass_count++;
      check_count++; if (out_pc !== 32'h200 + 32'(4 * i)) $display("FAIL decode_pc%0d: got %h expected %h", i, out_pc, 32'h200 + 32'(4 * i)); else pass_count++;
    end
    in_valid = 1'b0;
    tick();
    check_count++; if (illegal_cnt !== 8'd4) $display("FAIL table_illegal_cnt: got %0d expected 4", illegal_cnt); else pass_count++;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ir = 32'h0010_0093; in_pc = 32'h300;   // A: imm 1
    tick();
    check_count++; if ({out_valid, in_ready} !== 2'b11) $display("FAIL b2b_first: got %b expected 11", {out_valid, in_ready}); else pass_count++;
    in_ir = 32'h0020_0093; in_pc = 32'h304;                    // B: imm 2
    tick();
    check_count++; if (in_ready !== 1'b0) $display("FAIL b2b_full_ready: got %b expected 0", in_ready); else pass_count++;
    in_ir = 32'h0030_0093; in_pc = 32'h308;                    // C: imm 3
    tick();
    $display("b2b stalled: valid=%b imm=%0d pc=%h ready=%b", out_valid, imm, out_pc, in_ready);
    check_count++; if ({out_valid, imm, out_pc} !== {1'b1, 32'd1, 32'h300}) $display("FAIL b2b_hold: got %h expected %h", {out_valid, imm, out_pc}, {1'b1, 32'd1, 32'h300}); else pass_count++;
    check_count++; if (in_ready !== 1'b0) $display("FAIL b2b_still_full: got %b expected 0", in_ready); else pass_count++;
    out_ready = 1'b1;
    tick();
    $display("b2b out: imm=%0d pc=%h", imm, out_pc);
    check_count++; if ({out_valid, imm, out_pc} !== {1'b1, 32'd2, 32'h304}) $display("FAIL b2b_second: got %h expected %h", {out_valid, imm, out_pc}, {1'b1, 32'd2, 32'h304}); else pass_count++;
    check_count++; if (in_ready !== 1'b1) $display("FAIL b2b_ready_back: got %b expected 1", in_ready); else pass_count++;
    tick();
    in_valid = 1'b0;
    $display("b2b out: imm=%0d pc=%h", imm, out_pc);
    check_count++; if ({out_valid, imm, out_pc} !== {1'b1, 32'd3, 32'h308}) $display("FAIL b2b_third: got %h expected %h", {out_valid, imm, out_pc}, {1'b1, 32'd3, 32'h308}); else pass_count++;
    tick();
    check_count++; if (out_valid !== 1'b0) $display("FAIL b2b_no_dup: got %b expected 0", out_valid); else pass_count++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ir = 32'hFFFF_FFFF; in_pc = 32'h400;   // illegal, held
    tick();
    in_ir = 32'h0070_0093; in_pc = 32'h404;                    // goes to skid
    tick();
    check_count++; if (in_ready !== 1'b0) $display("FAIL flush_pre_full: got %b expected 0", in_ready); else pass_count++;
    flush = 1'b1; in_ir = 32'h0090_0093; in_pc = 32'h408;      // dropped
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    $display("flush: valid=%b ready=%b", out_valid, in_ready);
    check_count++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL flush_state: got %b expected 01", {out_valid, in_ready}); else pass_count++;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_count++; if (out_valid !== 1'b0) $display("FAIL flush_ghost%0d: got %b expected 0", i, out_valid); else pass_count++;
    end
    check_count++; if (illegal_cnt !== 8'd4) $display("FAIL flush_cnt: got %0d expected 4", illegal_cnt); else pass_count++;
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    in_valid = 1'b1; in_ir = 32'hFFFF_FFFF; in_pc = 32'h500;
    repeat (100) @(posedge clk);
    #1;
    in_valid = 1'b0;
    tick();
    $display("illegal_cnt after 100 more: %0d", illegal_cnt);
    check_count++; if (illegal_cnt !== 8'd104) $display("FAIL sat_mid: got %0d expected 104", illegal_cnt); else pass_count++;
    in_valid = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    in_valid = 1'b0;
    tick();
    $display("illegal_cnt after 200 more: %0d", illegal_cnt);
    check_count++; if (illegal_cnt !== 8'd255) $display("FAIL sat_top: got %0d expected 255", illegal_cnt); else pass_count++;
  endtask

  task automatic test_m_ext();
    out_ready_m = 1'b0;
    in_valid_m = 1'b1; in_ir_m = 32'h0220_81B3; in_pc_m = 32'h600;   // mul x3,x1,x2
    tick();
    $display("mul: rd=%0d rs1=%0d rs2=%0d alu=%0d we=%b ill=%b", dst_m, src1_m, src2_m, alucode_m, reg_we_m, is_illegal_m);
    check_count++; if ({dst_m, src1_m, src2_m, alucode_m, reg_we_m, is_illegal_m} !== {5'd3, 5'd1, 5'd2, ALU_MUL, 1'b1, 1'b0}) $display("FAIL mext_mul: got %h expected %h", {dst_m, src1_m, src2_m, alucode_m, reg_we_m, is_illegal_m}, {5'd3, 5'd1, 5'd2, ALU_MUL, 1'b1, 1'b0}); else pass_count++;
    check_count++; if (in_ready_m !== 1'b0) $display("FAIL noskid_stall_ready: got %b expected 0", in_ready_m); else pass_count++;
    in_ir_m = 32'h0262_D233; in_pc_m = 32'h604;                      // divu x4,x5,x6
    tick();
    check_count++; if ({alucode_m, out_pc_m} !== {ALU_MUL, 32'h600}) $display("FAIL noskid_hold: got %h expected %h", {alucode_m, out_pc_m}, {ALU_MUL, 32'h600}); else pass_count++;
    out_ready_m = 1'b1;
    #1;
    check_count++; if (in_ready_m !== 1'b1) $display("FAIL noskid_comb_ready: got %b expected 1", in_ready_m); else pass_count++;
    tick();
    in_valid_m = 1'b0;
    $display("divu: rd=%0d alu=%0d pc=%h", dst_m, alucode_m, out_pc_m);
    check_count++; if ({dst_m, alucode_m, out_pc_m} !== {5'd4, ALU_DIVU, 32'h604}) $display("FAIL mext_divu: got %h expected %h", {dst_m, alucode_m, out_pc_m}, {5'd4, ALU_DIVU, 32'h604}); else pass_count++;
    tick();
    check_count++; if (out_valid_m !== 1'b0) $display("FAIL noskid_drain: got %b expected 0", out_valid_m); else pass_count++;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ir = 32'h0050_0093; in_pc = 32'h44;
    tick();
    in_valid = 1'b0;
    check_count++; if (out_valid !== 1'b1) $display("FAIL areset_pre: got %b expected 1", out_valid); else pass_count++;
    #2;
    rst_n = 1'b0;
    #1;   // still well before the next rising edge
    $display("async reset: valid=%b ready=%b cnt=%0d", out_valid, in_ready, illegal_cnt);
    check_count++; if ({out_valid, in_ready, illegal_cnt} !== 10'd0) $display("FAIL areset_state: got %h expected 0", {out_valid, in_ready, illegal_cnt}); else pass_count++;
    check_count++; if ({out_pc, imm, dst, alucode} !== 75'd0) $display("FAIL areset_bundle: got %h expected 0", {out_pc, imm, dst, alucode}); else pass_count++;
    rst_n = 1'b1;
    tick();
    check_count++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL areset_after: got %b expected 01", {out_valid, in_ready}); else pass_count++;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_jal();
    test_decode_table();
    test_back_to_back();
    test_flush();
    test_saturate();
    test_m_ext();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
